piso_serializer: RTL

Parallel-in, serial-out word serializer. It accepts a WIDTH-bit word through a ready/valid handshake and shifts it out one bit per clock on `x`. It sits directly upstream of the serial sequence detector (the 1-0-1 Mealy detector) and drives that detector's `x` input. `x_valid` and `done` let the surrounding logic gate and count the detector's `y` output.

---
 rtl/piso_serializer_if.sv | 30 +++
 rtl/piso_serializer.sv | 97 +++++++++
 2 files changed

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The upstream producer uses the master view and the serializer uses the slave view.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             x;
  logic             x_valid;
  logic             done;

  modport master (
    output din,
    output load,
    input  ready,
    input  x,
    input  x_valid,
    input  done
  );

  modport slave (
    input  din,
    input  load,
    output ready,
    output x,
    output x_valid,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out word serializer with a ready/valid load handshake.
// Defining PISO_LSB_FIRST_EN sends bits LSB first; otherwise bits go MSB first.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             done_q, done_d;
  logic             last_bit;
  logic             accept;

`ifdef PISO_LSB_FIRST_EN
  function automatic logic head(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return {1'b0, v[WIDTH-1:1]};
  endfunction
`else
  function automatic logic head(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction
`endif

  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
  assign bus.ready = !rst && ((state_q == IDLE) || last_bit);
  assign accept    = bus.load && bus.ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      sr_d    = bus.din;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end else begin
        sr_d  = advance(sr_q);
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Outputs are registered copies of what the next state presents, so x
    // always equals the head of sr while shifting.
    x_valid_d = (state_d == SHIFT);
    x_d       = x_valid_d && head(sr_d);
    done_d    = x_valid_d && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.done    = done_q;

endmodule
